// File: rtl/tx_pulse_scheduler.sv
// rtl/tx_pulse_scheduler.sv - pulsed-Doppler transmit burst and range-gate sequencer
// Optional macro TX_PRF_COUNT_EN adds the prf_count output and the burst_limit input.
module tx_pulse_scheduler #(
  parameter int CNT_W     = 16,
  parameter int BURST_W   = 8,
  parameter int GUARD_MIN = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic [BURST_W-1:0] burst_len,
  input  logic [CNT_W-1:0]   prf_period,
  input  logic [CNT_W-1:0]   rx_delay,
  input  logic [CNT_W-1:0]   rx_len,
  input  logic [1:0]         freq_sel_in,
  output logic               gate,
  output logic [1:0]         freq_sel,
  output logic               rx_gate,
  output logic               prf_tick,
  output logic               busy,
  output logic               cfg_err
`ifdef TX_PRF_COUNT_EN
  ,
  input  logic [CNT_W-1:0]   burst_limit,
  output logic [CNT_W-1:0]   prf_count
`endif
);

  typedef enum logic [2:0] {IDLE, TX, GUARD, RX, HOLD} state_t;

  localparam logic [CNT_W:0]   X_ONE   = (CNT_W+1)'(1);
  localparam logic [CNT_W:0]   X_GUARD = (CNT_W+1)'(GUARD_MIN);
  localparam logic [CNT_W-1:0] T_ONE   = CNT_W'(1);

  state_t             state, state_n;
  logic [CNT_W-1:0]   t, t_n;
  logic [BURST_W-1:0] sh_burst;
  logic [CNT_W-1:0]   sh_prf, sh_rxd, sh_rxl;

  logic [CNT_W:0] in_bl, in_rxd, in_rxl, in_prf, sh_rx_end, t_inc;
  logic           at_end, latch, cfg_ok, load, err_set, run_ok;

`ifdef TX_PRF_COUNT_EN
  logic limit_hit, en_q, limit_stop;
  assign limit_stop = at_end && (burst_limit != '0) && (prf_count >= burst_limit);
  assign run_ok     = !limit_hit && !limit_stop;
`else
  assign run_ok = 1'b1;
`endif

  // All sums are one bit wider than the counters so overflow reads as invalid.
  always_comb begin
    in_bl     = (CNT_W+1)'(burst_len);
    in_rxd    = (CNT_W+1)'(rx_delay);
    in_rxl    = (CNT_W+1)'(rx_len);
    in_prf    = (CNT_W+1)'(prf_period);
    sh_rx_end = (CNT_W+1)'(sh_rxd) + (CNT_W+1)'(sh_rxl);
    t_inc     = (CNT_W+1)'(t) + X_ONE;

    cfg_ok  = (burst_len != '0) && (in_rxd >= in_bl + X_GUARD) && (rx_len != '0) &&
              (in_prf >= in_rxd + in_rxl + X_ONE) && (freq_sel_in != 2'b00);
    at_end  = (state != IDLE) && (t == sh_prf - T_ONE);
    latch   = enable && run_ok && ((state == IDLE) || at_end);
    load    = latch && cfg_ok;
    err_set = latch && !cfg_ok;

    state_n = IDLE;
    t_n     = '0;
    if (load) begin
      state_n = TX;
    end else if ((state != IDLE) && !at_end) begin
      t_n = t + T_ONE;
      if (t_inc < (CNT_W+1)'(sh_burst))
        state_n = TX;
      else if (t_inc < (CNT_W+1)'(sh_rxd))
        state_n = GUARD;
      else if (t_inc < sh_rx_end)
        state_n = RX;
      else
        state_n = HOLD;
    end
  end

  // Outputs are decoded from the next state so they switch on the same edge as the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      t        <= '0;
      sh_burst <= '0;
      sh_prf   <= '0;
      sh_rxd   <= '0;
      sh_rxl   <= '0;
      gate     <= 1'b0;
      rx_gate  <= 1'b0;
      prf_tick <= 1'b0;
      busy     <= 1'b0;
      cfg_err  <= 1'b0;
      freq_sel <= 2'b11;
    end else begin
      state <= state_n;
      t     <= t_n;
      if (load) begin
        sh_burst <= burst_len;
        sh_prf   <= prf_period;
        sh_rxd   <= rx_delay;
        sh_rxl   <= rx_len;
        freq_sel <= freq_sel_in;
      end
      gate     <= (state_n == TX);
      rx_gate  <= (state_n == RX);
      prf_tick <= load;
      busy     <= (state_n != IDLE);
      if (!enable)
        cfg_err <= 1'b0;
      else if (err_set)
        cfg_err <= 1'b1;
    end
  end

`ifdef TX_PRF_COUNT_EN
  // A fresh enable rising edge restarts the period count; limit_hit blocks rearming until enable drops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prf_count <= '0;
      limit_hit <= 1'b0;
      en_q      <= 1'b0;
    end else begin
      en_q <= enable;
      if (!enable)
        limit_hit <= 1'b0;
      else if (limit_stop)
        limit_hit <= 1'b1;
      if (load)
        prf_count <= ((state == IDLE) && !en_q) ? T_ONE : prf_count + T_ONE;
    end
  end
`endif

endmodule
